// File: rtl/wb_comp.sv
// wb_comp: wishbone initiator for the compressed-wishbone (cw) pin bus.
// Serialises one wishbone transfer into cw beats and returns the response.
// Ports: i_clk/i_rst (sync, active-high); wb_* wishbone slave side;
//   cw_io_o/cw_io_i/cw_req/cw_dir/cw_ack/cw_err cw pin side.
// Build option: define CW_TIMEOUT_EN for a WAIT-state watchdog that
//   ends the transfer with wb_err after TIMEOUT_CYCLES silent cycles.
module wb_comp #(
  parameter int ADDR_W = 24,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_adr,
  input  logic [15:0]       wb_i_dat,
  input  logic [1:0]        wb_sel,
  output logic [15:0]       wb_o_dat,
  output logic              wb_ack,
  output logic              wb_err,
  output logic [15:0]       cw_io_o,
  input  logic [15:0]       cw_io_i,
  output logic              cw_req,
  output logic              cw_dir,
  input  logic              cw_ack,
  input  logic              cw_err
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_LO,
    ADDR_HI,
    DATA,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      state_n;

  logic [23:0] adr_x;
  logic [23:0] adr_q;
  logic [15:0] dat_q;
  logic [1:0]  sel_q;
  logic        we_q;
  logic        drop_q;

  logic        take;
  logic        hit;
  logic        tmo;
  logic        live;

  logic [15:0] io_n;
  logic        req_n;
  logic        dir_n;
  logic        ack_n;
  logic        err_n;

  // Narrow addresses are zero-extended so the header's
  // upper address field reads as zero.
  assign adr_x = 24'(wb_adr);

  assign take = (state == IDLE) && wb_cyc && wb_stb;
  assign hit  = cw_ack || cw_err;
  // The cw bus cannot abort, so a master that lets go
  // only loses the response pulse, not the transfer.
  assign live = wb_cyc && !drop_q;

`ifdef CW_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (state != WAIT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // cnt counts completed WAIT cycles; the last allowed
  // WAIT cycle is number TIMEOUT_CYCLES.
  assign tmo = (state == WAIT) &&
               (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_to;

  assign unused_to = TIMEOUT_CYCLES;
  assign tmo       = 1'b0;
`endif

  // Outputs are registered from the next state, so each
  // output value lines up with the state it belongs to.
  always_comb begin
    state_n = state;
    io_n    = '0;
    req_n   = 1'b0;
    dir_n   = 1'b1;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (take) begin
          state_n = ADDR_LO;
          req_n   = 1'b1;
          io_n    = adr_x[15:0];
        end
      end
      ADDR_LO: begin
        state_n = ADDR_HI;
        io_n    = {we_q, sel_q, 5'b0, adr_q[23:16]};
      end
      ADDR_HI: begin
        if (we_q) begin
          state_n = DATA;
          io_n    = dat_q;
        end else begin
          state_n = WAIT;
          dir_n   = 1'b0;
        end
      end
      DATA: begin
        state_n = WAIT;
        dir_n   = 1'b0;
      end
      WAIT: begin
        dir_n = 1'b0;
        if (hit || tmo) begin
          state_n = RESP;
          dir_n   = 1'b1;
          ack_n   = live && cw_ack && !cw_err;
          err_n   = live && (cw_err || !hit);
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
    end else if (take) begin
      adr_q <= adr_x;
      dat_q <= wb_i_dat;
      sel_q <= wb_sel;
      we_q  <= wb_we;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      drop_q <= 1'b0;
    end else if (take) begin
      drop_q <= 1'b0;
    end else if (state != IDLE && !wb_cyc) begin
      drop_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cw_req  <= 1'b0;
      cw_dir  <= 1'b1;
      cw_io_o <= '0;
      wb_ack  <= 1'b0;
      wb_err  <= 1'b0;
    end else begin
      cw_req  <= req_n;
      cw_dir  <= dir_n;
      cw_io_o <= io_n;
      wb_ack  <= ack_n;
      wb_err  <= err_n;
    end
  end

  // An error (even alongside ack) leaves read data alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb_o_dat <= '0;
    end else if (state == WAIT && !we_q &&
                 cw_ack && !cw_err) begin
      wb_o_dat <= cw_io_i;
    end
  end

endmodule
